// File: rtl/eth_rx_frame_filter.sv
// eth_rx_frame_filter: forwards only the payload of frames for this node carrying the accelerator EtherType
module eth_rx_frame_filter #(
    parameter logic [47:0] LOCAL_MAC = 48'h000A35000102,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter bit          BCAST_EN  = 1'b1
) (
    input  logic        net_axis_clk,
    input  logic        net_axis_reset,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic [15:0] frames_accepted,
    output logic [15:0] frames_dropped
);
    typedef enum logic [1:0] {HDR, PASS, DROP} state_t;
    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        match_q, match_d, uni_q, uni_d, bc_q, bc_d;
    logic [7:0]  tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic [15:0] acc_q, acc_d, dropped_q, dropped_d;
    logic        beat, load;
    logic [7:0]  mac_byte, et_byte;

    assign s_axis_tready   = !net_axis_reset && (state_q != PASS || !tvalid_q || m_axis_tready);
    assign beat            = s_axis_tvalid && s_axis_tready;
    assign load            = beat && state_q == PASS;
    assign mac_byte        = 8'(LOCAL_MAC >> {3'd5 - idx_q[2:0], 3'b000});
    assign et_byte         = idx_q[0] ? ETHERTYPE[7:0] : ETHERTYPE[15:8];
    assign m_axis_tdata    = tdata_q;
    assign m_axis_tvalid   = tvalid_q;
    assign m_axis_tlast    = tlast_q;
    assign frames_accepted = acc_q;
    assign frames_dropped  = dropped_q;

    // Header parsing, accept/drop decision and frame counters; any tlast ends the frame back in HDR
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        match_d   = match_q;
        uni_d     = uni_q;
        bc_d      = bc_q;
        acc_d     = acc_q;
        dropped_d = dropped_q;
        if (beat) begin
            if (state_q == HDR) begin
                idx_d = idx_q + 4'd1;
                if (idx_q <= 4'd5) begin
                    uni_d = uni_q && s_axis_tdata == mac_byte;
                    bc_d  = bc_q && s_axis_tdata == 8'hFF;
                    if (idx_q == 4'd5) match_d = uni_d || (BCAST_EN && bc_d);
                end
                if (idx_q >= 4'd12 && s_axis_tdata != et_byte) match_d = 1'b0;
                if (idx_q == 4'd13) begin
                    state_d = match_d ? PASS : DROP;
                    idx_d   = 4'd0;
                end
            end
            if (s_axis_tlast) begin
                state_d = HDR;
                idx_d   = 4'd0;
                match_d = 1'b1;
                uni_d   = 1'b1;
                bc_d    = 1'b1;
                if (state_q == PASS) acc_d = acc_q + {15'd0, acc_q != 16'hFFFF};
                else dropped_d = dropped_q + {15'd0, dropped_q != 16'hFFFF};
            end
        end
    end

    // Output register: reload on a PASS beat, otherwise empty on a downstream transfer
    always_comb begin
        tdata_d  = load ? s_axis_tdata : tdata_q;
        tlast_d  = load ? s_axis_tlast : tlast_q;
        tvalid_d = load || (tvalid_q && !m_axis_tready);
    end

    // State registers with synchronous reset
    always_ff @(posedge net_axis_clk) begin
        if (net_axis_reset) begin
            state_q   <= HDR;
            idx_q     <= 4'd0;
            match_q   <= 1'b1;
            uni_q     <= 1'b1;
            bc_q      <= 1'b1;
            tdata_q   <= 8'd0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            acc_q     <= 16'd0;
            dropped_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            match_q   <= match_d;
            uni_q     <= uni_d;
            bc_q      <= bc_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            acc_q     <= acc_d;
            dropped_q <= dropped_d;
        end
    end
endmodule

// File: doc/eth_rx_frame_filter.md
# eth_rx_frame_filter

Receive-side frame filter between the TEMAC receive AXI-Stream (8-bit, `net_axis_clk` domain) and the encryption datapath. It parses the 14-byte Ethernet header on the fly and forwards only the payload of frames addressed to this node (unicast MAC or, optionally, broadcast) that carry the accelerator EtherType. All other frames are discarded. Accepted and dropped frames are counted for MicroBlaze status reads.

## Interface
- `LOCAL_MAC`, default 48'h000A35000102: station MAC; the first byte on the wire is bits [47:40].
- `ETHERTYPE`, default 16'h88B5: accepted EtherType; the first byte on the wire is bits [15:8].
- `BCAST_EN`, default 1: when 1, destination FF:FF:FF:FF:FF:FF also matches.

Ports:
- `net_axis_clk`  in  1  stream clock; the block uses this single clock.
- `net_axis_reset`  in  1  reset, **synchronous, active-high**.
- `s_axis_tdata`  in  8  received byte from the MAC.
- `s_axis_tvalid`  in  1  byte valid.
- `s_axis_tlast`  in  1  last byte of frame (FCS already stripped).
- `s_axis_tready`  out  1  filter ready for a byte.
- `m_axis_tdata`  out  8  payload byte.
- `m_axis_tvalid`  out  1  payload byte valid.
- `m_axis_tlast`  out  1  last payload byte.
- `m_axis_tready`  in  1  downstream ready.
- `frames_accepted`  out  16  count of frames forwarded; saturates at 16'hFFFF.
- `frames_dropped`  out  16  count of frames discarded; saturates at 16'hFFFF.

## Operation
- A beat is accepted when `s_axis_tvalid && s_axis_tready`. Output transfers complete when `m_axis_tvalid && m_axis_tready`.
- The state machine has three states: HDR, PASS, DROP. It holds a 4-bit byte index `idx` (0..13) and a `match` flag. `match` is set to 1 on entry to HDR.
- **HDR**
  - `s_axis_tready`=1.
  - Bytes at idx 0..5: compare against `LOCAL_MAC` (byte k against bits [47-8k -: 8]). Track the broadcast compare (all 8'hFF) in parallel. After idx 5, `match` = unicast_ok OR (`BCAST_EN` AND bcast_ok).
  - Bytes at idx 6..11: source MAC, ignored.
  - Bytes at idx 12..13: compare against `ETHERTYPE`. A mismatch clears `match`.
  - Accepted beat at idx 13 with tlast=0: go to PASS if `match`, else DROP. Reset `idx` to 0.
  - Accepted beat with tlast=1 at any idx 0..13 (runt or header-only frame): increment `frames_dropped`, stay in HDR, set `idx`=0 and `match`=1.
- **PASS**
  - `s_axis_tready` = !`m_axis_tvalid` || `m_axis_tready`.
  - Each accepted beat loads the output register with `m_axis_tdata`=byte and `m_axis_tlast`=s_tlast, and sets `m_axis_tvalid`=1.
  - Accepted beat with tlast=1: increment `frames_accepted`, go to HDR.
- **DROP**
  - `s_axis_tready`=1 and bytes are discarded.
  - Accepted beat with tlast=1: increment `frames_dropped`, go to HDR.
- The output register clears `m_axis_tvalid` on an output transfer unless it is reloaded in the same cycle.
- Counters saturate: an increment at 16'hFFFF holds the value at 16'hFFFF.

## Timing
- Reset values:
  - state HDR, `idx` 0, `match` 1.
  - `m_axis_tvalid` 0, `m_axis_tdata` 0, `m_axis_tlast` 0.
  - `frames_accepted` 0, `frames_dropped` 0.
  - `s_axis_tready` is 0 while `net_axis_reset` is high and 1 in the first cycle after.
- Latency: an accepted payload byte appears on `m_axis_*` the following cycle.
- Throughput: 1 byte/cycle in all states when `m_axis_tready`=1. In PASS, an output transfer and a new input accept in the same cycle reload the register without a bubble.
- Backpressure: in PASS with `m_axis_tvalid`=1 and `m_axis_tready`=0, `s_axis_tready`=0 and the output holds stable. In HDR and DROP the input is never stalled.
- `m_axis_tvalid` is never asserted for a header byte or for any byte of a dropped frame.
- A transition to HDR after a tlast takes effect the next cycle; the next frame's byte 0 may be accepted that cycle.
- Reset mid-frame: all state returns to reset values immediately. Any output byte held in the register is lost. Remaining input bytes are parsed as a new header and normally end in DROP.
- Counter updates are visible the cycle after the tlast beat is accepted.

## Test plan
- Unicast match: dest 00:0A:35:00:01:02, EtherType 88B5, payload 01..10 (16 bytes), `m_axis_tready`=1.
  - Expect 16 output bytes 01..10, tlast on 10, output starting the cycle after input byte 14.
  - Expect `frames_accepted`=1.
- Filtering, three frames:
  - Wrong dest MAC 00:0A:35:00:01:03.
  - Wrong EtherType 0800.
  - Broadcast dest with `BCAST_EN`=0.
  - Expect no `m_axis_tvalid`, `frames_dropped`=3, and `s_axis_tready` high throughout.
- Runt frames:
  - A 10-byte frame and a 14-byte header-only matching frame.
  - Expect no output and `frames_dropped`=2.
  - A following valid frame is forwarded intact.
- Backpressure: matching frame with 64-byte payload, `m_axis_tready` toggled randomly 50%.
  - Expect all 64 bytes in order with no loss or duplication.
  - Expect the output stable while stalled and `s_axis_tready` low exactly while stalled.
- Back-to-back and reset:
  - Two matching frames with no idle gap; expect both forwarded and `frames_accepted`=2.
  - Then assert reset at payload byte 5 of a third frame; expect outputs and counters at 0 the next cycle.
  - The rest of the third frame is not forwarded.
- Saturation: preload/force `frames_dropped`=16'hFFFE, then send 3 non-matching frames.
  - Expect values 16'hFFFF, 16'hFFFF, 16'hFFFF.
